// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP. The winning request's operands
// and op code are latched on accept and driven to the ALU during EXEC. The
// result is captured into a response register that holds until the owning
// requester accepts it.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, requester 0 always wins ties and no priority pointer exists.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_srca,
    input  logic [2*DATA_W-1:0]   req_srcb,
    input  logic [2*FUNC_W-1:0]   req_func,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_result,
    output logic                  resp_err,
    output logic [DATA_W-1:0]     alu_srca,
    output logic [DATA_W-1:0]     alu_srcb,
    output logic [FUNC_W-1:0]     alufunc,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Op codes 1..5 are the only ones the shared ALU implements.
    function automatic logic func_is_legal(input logic [FUNC_W-1:0] f);
        return (f >= FUNC_W'(1)) && (f <= FUNC_W'(5));
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          w_grant;
    logic                w_winner;
    logic                w_accept;
    logic                w_resp_hs;

    logic [DATA_W-1:0]   w_sel_srca;
    logic [DATA_W-1:0]   w_sel_srcb;
    logic [FUNC_W-1:0]   w_sel_func;

    logic                r_id;
    logic [DATA_W-1:0]   r_alu_srca;
    logic [DATA_W-1:0]   r_alu_srcb;
    logic [FUNC_W-1:0]   r_alufunc;
    logic [1:0]          r_resp_valid;
    logic [DATA_W-1:0]   r_resp_result;
    logic                r_resp_err;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic                r_ptr;
`endif

    // Arbitration: pick a winner among the valid requesters, only while idle.
    always_comb begin
        w_grant  = 2'b00;
        w_winner = 1'b0;
        if (r_state == ST_IDLE) begin
            case (req_valid)
                2'b01: begin
                    w_grant  = 2'b01;
                    w_winner = 1'b0;
                end
                2'b10: begin
                    w_grant  = 2'b10;
                    w_winner = 1'b1;
                end
                2'b11: begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    w_winner = r_ptr;
                    w_grant  = r_ptr ? 2'b10 : 2'b01;
`else
                    w_winner = 1'b0;
                    w_grant  = 2'b01;
`endif
                end
                default: begin
                    w_grant  = 2'b00;
                    w_winner = 1'b0;
                end
            endcase
        end else begin
            w_grant  = 2'b00;
            w_winner = 1'b0;
        end
    end

    // A grant is only ever raised on a valid requester, so any grant is an accept.
    assign w_accept  = |w_grant;
    // Only the owner's resp_ready bit can complete the handshake.
    assign w_resp_hs = |(r_resp_valid & resp_ready);

    // Select the winning lane's operands and op code.
    always_comb begin
        w_sel_srca = '0;
        w_sel_srcb = '0;
        w_sel_func = '0;
        if (w_winner) begin
            w_sel_srca = req_srca[DATA_W +: DATA_W];
            w_sel_srcb = req_srcb[DATA_W +: DATA_W];
            w_sel_func = req_func[FUNC_W +: FUNC_W];
        end else begin
            w_sel_srca = req_srca[0 +: DATA_W];
            w_sel_srcb = req_srcb[0 +: DATA_W];
            w_sel_func = req_func[0 +: FUNC_W];
        end
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_resp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, ALU drive and response capture. A reset here drops any
    // in-flight op without ever raising resp_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_id          <= 1'b0;
            r_alu_srca    <= '0;
            r_alu_srcb    <= '0;
            r_alufunc     <= '0;
            r_resp_valid  <= 2'b00;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id       <= w_winner;
                        r_alu_srca <= w_sel_srca;
                        r_alu_srcb <= w_sel_srcb;
                        r_alufunc  <= w_sel_func;
                    end else begin
                        r_alu_srca <= '0;
                        r_alu_srcb <= '0;
                        r_alufunc  <= '0;
                    end
                    r_resp_valid <= 2'b00;
                end
                ST_EXEC: begin
                    // ALU inputs return to zero as the op leaves EXEC.
                    r_alu_srca <= '0;
                    r_alu_srcb <= '0;
                    r_alufunc  <= '0;
                    if (func_is_legal(r_alufunc)) begin
                        r_resp_result <= alu_result;
                        r_resp_err    <= 1'b0;
                    end else begin
                        r_resp_result <= '0;
                        r_resp_err    <= 1'b1;
                    end
                    r_resp_valid <= r_id ? 2'b10 : 2'b01;
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= 2'b00;
                    end else begin
                        r_resp_valid <= r_resp_valid;
                    end
                end
                default: begin
                    r_alu_srca   <= '0;
                    r_alu_srcb   <= '0;
                    r_alufunc    <= '0;
                    r_resp_valid <= 2'b00;
                end
            endcase
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Priority pointer: after serving requester i, prefer the other one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_winner;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign req_ready   = w_grant;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;
    assign alu_srca    = r_alu_srca;
    assign alu_srcb    = r_alu_srcb;
    assign alufunc     = r_alufunc;
    assign busy        = (r_state != ST_IDLE);

endmodule
